// File: rtl/serial_word_receiver_pkg.sv
// serial_rx_pkg: shared types and constants for serial_word_receiver.
//   rx_state_t : receiver FSM states (PARITY is only reachable when
//                SERIAL_RX_PARITY_EN is defined).
//   MODE_*     : bit-order select codes, ordered {m0,m1}, matching the
//                4-bit universal shift register encoding.
package serial_rx_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } rx_state_t;

  localparam logic [1:0] MODE_HOLD      = 2'b00;
  localparam logic [1:0] MODE_LSB_FIRST = 2'b01;
  localparam logic [1:0] MODE_MSB_FIRST = 2'b10;
  localparam logic [1:0] MODE_LOAD      = 2'b11;  // no capture, same as hold

  // Only the two shift modes start a word; hold and load drop the bit.
  function automatic logic is_capture_mode(input logic [1:0] mode);
    return (mode == MODE_LSB_FIRST) || (mode == MODE_MSB_FIRST);
  endfunction

endpackage

// File: rtl/serial_word_receiver_if.sv
// serial_word_receiver_if: serial input / parallel output bundle.
//   master : bit source and word consumer (drives m0, m1, ser_in,
//            ser_valid, flush, out_ready; observes the rest)
//   slave  : the receiver (drives p_out, out_valid, overrun,
//            parity_err, busy)
interface serial_word_receiver_if
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = 4
) ();

  logic             m0;
  logic             m1;
  logic             ser_in;
  logic             ser_valid;
  logic             flush;
  logic             out_ready;
  logic [WIDTH-1:0] p_out;
  logic             out_valid;
  logic             overrun;
  logic             parity_err;
  logic             busy;

  modport master (
    output m0, m1, ser_in, ser_valid, flush, out_ready,
    input  p_out, out_valid, overrun, parity_err, busy
  );

  modport slave (
    input  m0, m1, ser_in, ser_valid, flush, out_ready,
    output p_out, out_valid, overrun, parity_err, busy
  );

endinterface

// File: rtl/serial_word_receiver_rx_hold_reg.sv
// rx_hold_reg: single-entry output register with valid/ready handshake
// and sticky overrun detection.
//   clk, clr   : clock, asynchronous active-high reset
//   i_load     : a completed word is offered this cycle
//   i_word     : the completed word
//   i_perr     : parity flag travelling with the word
//   i_ready    : consumer accepts o_data this cycle
//   o_data     : held word (keeps last value after consumption)
//   o_valid    : o_data holds an unconsumed word
//   o_overrun  : sticky, a completed word found the register full
//   o_perr     : parity flag of the held word
module rx_hold_reg
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_perr,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic             o_overrun,
  output logic             o_perr
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_overrun;
  logic             r_perr;
  logic             w_space;

  // The register can take a word if empty or if it drains on this edge.
  assign w_space = !r_valid || i_ready;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      if (i_load && w_space) begin
        r_data  <= i_word;
        r_perr  <= i_perr;
        r_valid <= 1'b1;
      end else if (i_ready) begin
        r_valid <= 1'b0;
      end
      if (i_load && !w_space) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_overrun = r_overrun;
  assign o_perr    = r_perr;

endmodule

// File: rtl/serial_word_receiver.sv
// serial_word_receiver: reassembles WIDTH-bit words from the serial
// stream of the 4-bit universal shift register (right_out in LSB-first
// mode, left_out in MSB-first mode) and presents them with valid/ready.
//   clk  : clock, rising edge
//   clr  : asynchronous active-high reset
//   bus  : serial_word_receiver_if.slave
//          in : m0, m1 (bit order, {m0,m1}), ser_in, ser_valid, flush,
//               out_ready
//          out: p_out, out_valid, overrun, parity_err, busy
// Build option: SERIAL_RX_PARITY_EN adds one even-parity bit per word
// (PARITY state); without it parity_err is tied to 0.
module serial_word_receiver
  import serial_rx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input logic                 clk,
  input logic                 clr,
  serial_word_receiver_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  rx_state_t        r_state;
  rx_state_t        w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [CNT_W-1:0] r_count;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_in;
  logic [1:0]       w_mode_eff;
  logic             w_take_data;
  logic             w_last_data;
  logic             w_complete;
  logic             w_parity_bad;
  logic [WIDTH-1:0] w_word;
`ifdef SERIAL_RX_PARITY_EN
  logic             w_take_par;
`endif

  function automatic logic [WIDTH-1:0] insert_bit(input logic [WIDTH-1:0] cur,
                                                  input logic [1:0]       mode,
                                                  input logic             b);
    if (mode == MODE_MSB_FIRST) return {cur[WIDTH-2:0], b};
    return {b, cur[WIDTH-1:1]};
  endfunction

  assign w_mode_in   = {bus.m0, bus.m1};
  // The live mode only matters for the first bit; afterwards the latched one rules.
  assign w_mode_eff  = (r_state == IDLE) ? w_mode_in : r_mode;
  assign w_shift_nxt = insert_bit(r_shift, w_mode_eff, bus.ser_in);

  // FSM state register
  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic; flush beats any accepted bit
  always_comb begin
    w_state_nxt = r_state;
    if (bus.flush) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:  if (w_take_data) w_state_nxt = SHIFT;
`ifdef SERIAL_RX_PARITY_EN
        SHIFT:  if (w_last_data) w_state_nxt = PARITY;
        PARITY: if (w_take_par)  w_state_nxt = IDLE;
`else
        SHIFT:  if (w_last_data) w_state_nxt = IDLE;
`endif
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs: bit-accept strobes and busy
  always_comb begin
    w_take_data = 1'b0;
    w_last_data = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    w_take_par  = 1'b0;
`endif
    bus.busy    = (r_state != IDLE);
    if (bus.ser_valid && !bus.flush) begin
      case (r_state)
        IDLE:  w_take_data = is_capture_mode(w_mode_in);
        SHIFT: begin
          w_take_data = 1'b1;
          w_last_data = (r_count == CNT_W'(WIDTH - 1));
        end
`ifdef SERIAL_RX_PARITY_EN
        PARITY: w_take_par = 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  // Data is already complete in r_shift when the parity bit arrives.
  assign w_complete   = w_take_par;
  assign w_word       = r_shift;
  assign w_parity_bad = (^r_shift) ^ bus.ser_in;
`else
  assign w_complete   = w_last_data;
  assign w_word       = w_shift_nxt;
  assign w_parity_bad = 1'b0;
`endif

  // Shift register, bit counter and latched mode
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_shift <= '0;
      r_count <= '0;
      r_mode  <= MODE_HOLD;
    end else if (bus.flush) begin
      r_count <= '0;
    end else if (w_take_data) begin
      r_shift <= w_shift_nxt;
      r_count <= w_last_data ? '0 : r_count + CNT_W'(1);
      if (r_state == IDLE) r_mode <= w_mode_in;
    end
  end

  rx_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk      (clk),
    .clr      (clr),
    .i_load   (w_complete),
    .i_word   (w_word),
    .i_perr   (w_parity_bad),
    .i_ready  (bus.out_ready),
    .o_data   (bus.p_out),
    .o_valid  (bus.out_valid),
    .o_overrun(bus.overrun),
    .o_perr   (bus.parity_err)
  );

endmodule
